// File: rtl/stream_gen_pkg.sv
// Shared types for the stream source generator: pattern modes and FSM states.
package stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_gen_next.sv
// Combinational next-value unit for the stream data patterns; reusable by checkers.
module stream_gen_next
  import stream_gen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(8'hB8)
) (
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives data_o and no latch is inferred.
    data_o = data_i;
    case (mode_i)
      MODE_INC:  data_o = data_i + DATA_W'(1);
      MODE_DEC:  data_o = data_i - DATA_W'(1);
      MODE_LFSR: data_o = data_i[0] ? ((data_i >> 1) ^ LFSR_POLY) : (data_i >> 1);
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/stream_source_gen.sv
// Programmable valid/ready stimulus source: pattern, burst length, inter-beat gap,
// stop control and completion pulse. All outputs are registered.
module stream_source_gen
  import stream_gen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       GAP_W     = 4,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(8'hB8)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              stop_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sent_cnt_o
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_beat;
  logic [DATA_W-1:0] data_nxt;

  assign xfer      = valid_q & ready_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_beat = (len_q != '0) && (cnt_inc == len_q);

  stream_gen_next #(
    .DATA_W    (DATA_W),
    .LFSR_POLY (LFSR_POLY)
  ) u_next (
    .mode_i (mode_q),
    .data_i (data_q),
    .data_o (data_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A pending beat must transfer before stop is honoured; in GAP stop exits at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_SEND;
      ST_SEND: begin
        if (xfer) begin
          if (last_beat || stop_i) state_d = ST_IDLE;
          else if (gap_q != '0)    state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop_i)                          state_d = ST_IDLE;
        else if (gap_cnt_q == GAP_W'(1))     state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    valid_d   = (state_d == ST_SEND);
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d = mode_e'(mode_i);
          len_d  = len_i;
          gap_d  = gap_i;
          cnt_d  = '0;
          // An all-zero LFSR state would lock up, so substitute 1.
          data_d = (mode_e'(mode_i) == MODE_LFSR && seed_i == '0) ? DATA_W'(1) : seed_i;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          cnt_d     = cnt_inc;
          data_d    = data_nxt;
          gap_cnt_d = gap_q;
          done_d    = (state_d == ST_IDLE);
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        done_d    = (state_d == ST_IDLE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn_i) begin
      mode_q    <= MODE_INC;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_stream_source_gen.sv
// Scoreboard bench for stream_source_gen: driver pushes expected beats on start,
// a negedge monitor runs a behavioural model and pops on each transfer.
module tb_stream_source_gen;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int GAP_W  = 4;

  logic              clk_i   = 1'b0;
  logic              rstn_i  = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i  = '0;
  logic [CNT_W-1:0]  len_i   = '0;
  logic [GAP_W-1:0]  gap_i   = '0;
  logic [DATA_W-1:0] seed_i  = '0;
  logic              stop_i  = 1'b0;
  logic              ready_i = 1'b0;
  logic              valid_o, busy_o, done_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  sent_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];

  bit               m_busy   = 1'b0;
  bit               m_valid  = 1'b0;
  bit               m_done   = 1'b0;
  logic [CNT_W-1:0] m_cnt    = '0;
  int               m_len    = 0;
  int               m_gap    = 0;
  int               gap_left = 0;

  always #5 clk_i = ~clk_i;

  stream_source_gen #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .len_i      (len_i),
    .gap_i      (gap_i),
    .seed_i     (seed_i),
    .stop_i     (stop_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sent_cnt_o (sent_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat i of a burst, straight from the pattern definitions.
  function automatic logic [DATA_W-1:0] ref_beat(input int m, input logic [DATA_W-1:0] seed,
                                                 input int i);
    logic [DATA_W-1:0] d;
    case (m)
      0:       return seed + DATA_W'(i);
      1:       return seed - DATA_W'(i);
      3:       return seed;
      default: begin
        d = (seed == '0) ? DATA_W'(1) : seed;
        for (int k = 0; k < i; k++) d = d[0] ? ((d >> 1) ^ DATA_W'(8'hB8)) : (d >> 1);
        return d;
      end
    endcase
  endfunction

  task automatic model_end();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_done  = 1'b1;
    exp_q.delete();
  endtask

  // Monitor: compare current outputs, then advance the model with the inputs
  // that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk_i);
      check("valid", 32'(valid_o), 32'(m_valid));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("done", 32'(done_o), 32'(m_done));
      check("sent_cnt", 32'(sent_cnt_o), 32'(m_cnt));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data: got %0h with no expected beat queued at %0t", data_o, $time);
        end else begin
          check("data", 32'(data_o), 32'(exp_q[0]));
        end
      end
      m_done = 1'b0;
      if (!rstn_i) begin
        m_busy   = 1'b0;
        m_valid  = 1'b0;
        m_cnt    = '0;
        gap_left = 0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (start_i) begin
          m_busy  = 1'b1;
          m_valid = 1'b1;
          m_cnt   = '0;
          m_len   = int'(len_i);
          m_gap   = int'(gap_i);
        end
      end else if (m_valid) begin
        if (ready_i) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_cnt = m_cnt + CNT_W'(1);
          if ((m_len != 0 && int'(m_cnt) == m_len) || stop_i) model_end();
          else if (m_gap != 0) begin
            m_valid  = 1'b0;
            gap_left = m_gap;
          end
        end
      end else begin
        if (stop_i) model_end();
        else begin
          gap_left--;
          if (gap_left == 0) m_valid = 1'b1;
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk_i); #1;
    rstn_i  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    ready_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_cnt", 32'(sent_cnt_o), 32'd0);
    rstn_i = 1'b1;
  endtask

  // stop_at: loop cycle from which stop_i is held (0 also raises it with start; -1 none).
  // reset_at: loop cycle at which a reset is applied instead of finishing (-1 none).
  task automatic run_burst(input int mode, input int len, input int gap,
                           input logic [DATA_W-1:0] seed, input int ready_pct,
                           input int hold_off, input int stop_at, input int reset_at,
                           input bit spurious);
    int n;
    int k;
    @(posedge clk_i); #1;
    for (int w = 0; m_busy && w < 100; w++) begin
      @(posedge clk_i); #1;
    end
    start_i = 1'b1;
    stop_i  = (stop_at == 0);
    ready_i = 1'b0;
    mode_i  = 2'(mode);
    len_i   = CNT_W'(len);
    gap_i   = GAP_W'(gap);
    seed_i  = seed;
    n = (len == 0) ? 300 : len;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_beat(mode, seed, i));
    k = 0;
    forever begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (!m_busy) break;
      if (reset_at >= 0 && k == reset_at) begin
        ready_i = 1'b0;
        do_reset(1);
        break;
      end
      if (k > 3000) begin
        checks++;
        errors++;
        $display("FAIL burst_timeout: still busy after %0d cycles, required idle", k);
        do_reset(1);
        break;
      end
      ready_i = (k >= hold_off) && (int'($urandom_range(99)) < ready_pct);
      stop_i  = (stop_at >= 0) && (k >= stop_at);
      if (spurious && $urandom_range(3) == 0) begin
        start_i = 1'b1;
        mode_i  = 2'($urandom_range(3));
        len_i   = CNT_W'($urandom_range(9));
        gap_i   = GAP_W'($urandom_range(3));
        seed_i  = DATA_W'($urandom_range(255));
      end
      k++;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    ready_i = 1'b0;
  endtask

  initial begin
    int len, gap, stop_at;
    do_reset(2);
    run_burst(0, 4, 0, 8'hFE, 100, 0, -1, -1, 1'b0);
    run_burst(1, 3, 2, 8'h01, 100, 0, -1, -1, 1'b0);
    run_burst(2, 4, 0, 8'h00, 100, 0, -1, -1, 1'b0);
    run_burst(0, 3, 0, 8'h10, 100, 5, -1, -1, 1'b0);
    run_burst(3, 0, 0, 8'hA5, 100, 5, 1, -1, 1'b0);
    run_burst(3, 0, 3, 8'hA5, 100, 0, 2, -1, 1'b0);
    @(posedge clk_i); #1;
    stop_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    stop_i = 1'b0;
    run_burst(0, 5, 1, 8'h20, 100, 0, 0, -1, 1'b0);
    run_burst(0, 5, 0, 8'h30, 100, 100, -1, 3, 1'b0);
    repeat (3) @(posedge clk_i);
    run_burst(0, 1, 2, 8'h40, 100, 0, -1, -1, 1'b1);
    run_burst(2, 6, 1, 8'h5A, 60, 0, -1, -1, 1'b1);
    for (int b = 0; b < 40; b++) begin
      len = ($urandom_range(6) == 0) ? 0 : int'($urandom_range(8, 1));
      gap = ($urandom_range(7) == 0) ? 15 : int'($urandom_range(3));
      if (len == 0) stop_at = int'($urandom_range(30, 3));
      else stop_at = ($urandom_range(4) == 0) ? int'($urandom_range(20)) : -1;
      run_burst(int'($urandom_range(3)), len, gap, DATA_W'($urandom_range(255)),
                int'($urandom_range(100, 30)), int'($urandom_range(3)), stop_at, -1,
                $urandom_range(1) == 1);
    end
    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
